// File: rtl/hazard_ctrl_if.sv
// Hazard sequencer bundle: the decode/exe/mem hazard sources in, stall/flush/error/perf out.
// The pipeline side uses the master modport; hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_decode;
    logic [4:0]       rs2_decode;
    logic             use_rs1_decode;
    logic             use_rs2_decode;
    logic [4:0]       rd_exe;
    logic             RegWrite_exe;
    logic             MemRead_exe;
    logic             branch_taken_exe;
    logic             mem_access_mem;
    logic             dmem_ready;
    logic             stall_fetch;
    logic             stall_decode;
    logic             stall_exe;
    logic             stall_mem;
    logic             flush_decode;
    logic             flush_exe;
    logic             bus_err;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;
    logic [CNT_W-1:0] perf_lu_cnt;

    modport master (
        output rs1_decode, rs2_decode, use_rs1_decode, use_rs2_decode,
        output rd_exe, RegWrite_exe, MemRead_exe, branch_taken_exe,
        output mem_access_mem, dmem_ready,
        input  stall_fetch, stall_decode, stall_exe, stall_mem,
        input  flush_decode, flush_exe, bus_err,
        input  perf_stall_cnt, perf_flush_cnt, perf_lu_cnt
    );

    modport slave (
        input  rs1_decode, rs2_decode, use_rs1_decode, use_rs2_decode,
        input  rd_exe, RegWrite_exe, MemRead_exe, branch_taken_exe,
        input  mem_access_mem, dmem_ready,
        output stall_fetch, stall_decode, stall_exe, stall_mem,
        output flush_decode, flush_exe, bus_err,
        output perf_stall_cnt, perf_flush_cnt, perf_lu_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubble, branch flush, data-memory freeze with timeout.
// Define HAZARD_PERF_CNT_EN to build the three performance counters; otherwise they read 0.
module hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        mem_stall;
    logic        lu;
    logic        lu_bubble;
    logic        branch_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        mem_stall  = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.mem_access_mem && !hz.dmem_ready) begin
                    mem_stall  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            MEM_WAIT: begin
                // The release cycle is not a stall: hazards resolve normally in it.
                if (hz.dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ERR;
                        bus_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end
            end
            ERR:     mem_stall = 1'b1;
            default: state_d   = RUN;
        endcase
    end

    assign lu = hz.MemRead_exe && hz.RegWrite_exe && (hz.rd_exe != 5'd0) &&
                ((hz.use_rs1_decode && (hz.rd_exe == hz.rs1_decode)) ||
                 (hz.use_rs2_decode && (hz.rd_exe == hz.rs2_decode)));

    // Priority: memory freeze, then wrong-path flush, then the load-use bubble.
    assign branch_flush = hz.branch_taken_exe && !mem_stall;
    assign lu_bubble    = lu && !mem_stall && !hz.branch_taken_exe;

    assign hz.stall_fetch  = mem_stall | lu_bubble;
    assign hz.stall_decode = mem_stall | lu_bubble;
    assign hz.stall_exe    = mem_stall;
    assign hz.stall_mem    = mem_stall;
    assign hz.flush_decode = branch_flush;
    assign hz.flush_exe    = branch_flush | lu_bubble;
    assign hz.bus_err      = bus_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

    assign stall_cnt_d = stall_cnt_q + CNT_W'(hz.stall_fetch);
    assign flush_cnt_d = flush_cnt_q + CNT_W'(hz.flush_decode);
    assign lu_cnt_d    = lu_cnt_q + CNT_W'(lu_bubble);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign hz.perf_stall_cnt = stall_cnt_q;
    assign hz.perf_flush_cnt = flush_cnt_q;
    assign hz.perf_lu_cnt    = lu_cnt_q;
`else
    assign hz.perf_stall_cnt = '0;
    assign hz.perf_flush_cnt = '0;
    assign hz.perf_lu_cnt    = '0;
`endif
endmodule
